// File: rtl/des_region_scheduler_pkg.sv
// Shared definitions for the DES region scheduler: FSM encoding and default sizing.
package des_region_scheduler_pkg;

    localparam int unsigned DEF_NUM_BLK = 4;
    localparam int unsigned DEF_N       = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_t;

endpackage

// File: rtl/prio_enc_lsb.sv
// One-hot lowest-index grant: isolates the least significant set bit of req.
module prio_enc_lsb
    import des_region_scheduler_pkg::*;
#(
    parameter int unsigned W = DEF_NUM_BLK
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] grant,
    output logic         valid
);

    assign grant = req & (~req + W'(1));
    assign valid = |req;

endmodule

// File: rtl/des_region_scheduler.sv
// Hands out a contiguous range of regions to a pool of des_block slots and sums
// the counters they report back, one dispatch and one collection per cycle.
module des_region_scheduler
    import des_region_scheduler_pkg::*;
#(
    parameter int unsigned NUM_BLK = DEF_NUM_BLK,
    parameter int unsigned N       = DEF_N
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [N-1:0]                region_first,
    input  logic [N-1:0]                region_last,
    output logic [NUM_BLK-1:0]          blk_start,
    output logic [NUM_BLK-1:0]          blk_restart,
    output logic [NUM_BLK*N-1:0]        blk_region,
    input  logic [NUM_BLK-1:0]          blk_done,
    input  logic [NUM_BLK*(64-N)-1:0]   blk_counter,
    output logic [63:0]                 total_count,
    output logic [N:0]                  regions_done,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned CW = 64 - N;

    state_t               state, state_d;
    logic [NUM_BLK-1:0]   slot_busy;
    logic [N-1:0]         next_region, last_region;
    logic [NUM_BLK-1:0]   free_grant, done_grant, dispatch_mask, collect_mask;
    logic                 free_valid, done_valid;
    logic                 in_job, accept, kill, dispatch, collect;
    logic [CW-1:0]        collect_count;

    prio_enc_lsb #(.W(NUM_BLK)) u_free_enc (
        .req   (~slot_busy),
        .grant (free_grant),
        .valid (free_valid)
    );

    // Only busy slots are eligible, so stray done levels on idle slots are dropped.
    prio_enc_lsb #(.W(NUM_BLK)) u_done_enc (
        .req   (slot_busy & blk_done),
        .grant (done_grant),
        .valid (done_valid)
    );

    assign in_job        = (state == StRun) || (state == StDrain);
    assign accept        = ((state == StIdle) || (state == StDone)) && start && !abort &&
                           (region_first <= region_last);
    assign kill          = abort && in_job;
    assign dispatch      = (state == StRun) && free_valid && !abort;
    assign collect       = in_job && done_valid && !abort;
    assign dispatch_mask = dispatch ? free_grant : '0;
    assign collect_mask  = collect ? done_grant : '0;

    always_comb begin
        collect_count = '0;
        for (int i = 0; i < NUM_BLK; i++) begin
            if (done_grant[i]) collect_count = collect_count | blk_counter[i*CW +: CW];
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            StIdle, StDone: begin
                if (accept)     state_d = StRun;
                else if (abort) state_d = StIdle;
            end
            // Leaving on the last dispatch avoids incrementing past 2^N-1.
            StRun: begin
                if (abort)                                          state_d = StIdle;
                else if (dispatch && (next_region == last_region))  state_d = StDrain;
            end
            StDrain: begin
                if (abort)                state_d = StIdle;
                else if (slot_busy == '0) state_d = StDone;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= StIdle;
            slot_busy    <= '0;
            blk_start    <= '0;
            blk_restart  <= '0;
            blk_region   <= '0;
            total_count  <= '0;
            regions_done <= '0;
            next_region  <= '0;
            last_region  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state       <= state_d;
            busy        <= (state_d == StRun) || (state_d == StDrain);
            done        <= (state_d == StDone);
            blk_start   <= '0;
            blk_restart <= '0;
            if (accept) begin
                total_count  <= '0;
                regions_done <= '0;
                next_region  <= region_first;
                last_region  <= region_last;
            end
            if (kill) begin
                blk_restart <= slot_busy;
                slot_busy   <= '0;
            end else begin
                slot_busy <= (slot_busy | dispatch_mask) & ~collect_mask;
                if (dispatch) begin
                    blk_start   <= free_grant;
                    next_region <= next_region + N'(1);
                    for (int i = 0; i < NUM_BLK; i++) begin
                        if (free_grant[i]) blk_region[i*N +: N] <= next_region;
                    end
                end
                if (collect) begin
                    blk_restart  <= done_grant;
                    total_count  <= total_count + 64'(collect_count);
                    regions_done <= regions_done + (N+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_des_region_scheduler.sv
// Directed bench for des_region_scheduler: table of whole jobs against a block
// model, plus hand sequences for simultaneous done, abort, reset and N=4 edges.
module tb_des_region_scheduler;

    localparam int NB = 4;
    localparam int N  = 16;
    localparam int CW = 64 - N;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0, abort = 1'b0;
    logic [N-1:0]      region_first = '0, region_last = '0;
    logic [NB-1:0]     blk_start, blk_restart, blk_done;
    logic [NB*N-1:0]   blk_region;
    logic [NB*CW-1:0]  blk_counter;
    logic [63:0]       total_count;
    logic [N:0]        regions_done;
    logic              busy, done;

    // second instance with N=4 for the top-of-range and wide-counter case
    logic              start4 = 1'b0;
    logic [3:0]        first4 = '0, last4 = '0;
    logic [NB-1:0]     blk_start4, blk_restart4;
    logic [NB*4-1:0]   blk_region4;
    logic [NB*60-1:0]  blk_counter4;
    logic [63:0]       total4;
    logic [4:0]        regions_done4;
    logic              busy4, done4;

    assign blk_counter4 = '1;

    always #5 clk = ~clk;

    des_region_scheduler #(.NUM_BLK(NB), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .region_first(region_first), .region_last(region_last),
        .blk_start(blk_start), .blk_restart(blk_restart), .blk_region(blk_region),
        .blk_done(blk_done), .blk_counter(blk_counter), .total_count(total_count),
        .regions_done(regions_done), .busy(busy), .done(done)
    );

    des_region_scheduler #(.NUM_BLK(NB), .N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(1'b0),
        .region_first(first4), .region_last(last4),
        .blk_start(blk_start4), .blk_restart(blk_restart4), .blk_region(blk_region4),
        .blk_done(4'hF), .blk_counter(blk_counter4), .total_count(total4),
        .regions_done(regions_done4), .busy(busy4), .done(done4)
    );

    // block model: done after a latency, counter = slot+1 or 3*region+7
    int          cur_lat = 20;
    bit          cur_cmode = 1'b0;
    bit          man = 1'b0;
    logic [NB-1:0] man_done = '0;
    int          lat [NB];
    logic [NB-1:0] mdone;
    logic [CW-1:0] mcnt [NB];

    always @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (!rst_n || blk_restart[i]) begin
                lat[i]   <= 0;
                mdone[i] <= 1'b0;
                if (!rst_n) mcnt[i] <= '0;
            end else if (blk_start[i]) begin
                lat[i]   <= (cur_lat == 0) ? int'($urandom_range(12, 1)) : cur_lat;
                mdone[i] <= 1'b0;
                mcnt[i]  <= cur_cmode ? (CW'(blk_region[i*N +: N]) * 3 + 7) : CW'(i + 1);
            end else if (lat[i] != 0) begin
                lat[i] <= lat[i] - 1;
                if (lat[i] == 1) mdone[i] <= 1'b1;
            end
        end
    end

    assign blk_done = man ? man_done : mdone;

    always_comb begin
        blk_counter = '0;
        for (int i = 0; i < NB; i++) blk_counter[i*CW +: CW] = mcnt[i];
    end

    // dispatch bookkeeping
    int cyc = 0;
    int nstarts = 0;
    int n4 = 0;
    int start_cyc [NB];
    int disp_cnt [int];

    always @(posedge clk) begin
        cyc++;
        n4 += $countones(blk_start4);
        for (int i = 0; i < NB; i++) begin
            if (blk_start[i]) begin
                nstarts++;
                start_cyc[i] = cyc;
                disp_cnt[int'(blk_region[i*N +: N])]++;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [N-1:0] f, input logic [N-1:0] l);
        region_first = f;
        region_last  = l;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int k = 0; k < limit && !done; k++) tick();
    endtask

    typedef struct {
        logic [N-1:0] first;
        logic [N-1:0] last;
        int           lat;
        bit           cmode;
        int           exp_regions;
        logic [63:0]  exp_total;
    } row_t;

    row_t rows [5];

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rows[0] = '{first: 16'd7,      last: 16'd3,      lat: 20, cmode: 1'b0,
                    exp_regions: 0,  exp_total: 64'd0};
        rows[1] = '{first: 16'd0,      last: 16'd3,      lat: 20, cmode: 1'b0,
                    exp_regions: 4,  exp_total: 64'd10};
        rows[2] = '{first: 16'd5,      last: 16'd14,     lat: 0,  cmode: 1'b1,
                    exp_regions: 10, exp_total: 64'd355};
        rows[3] = '{first: 16'd9,      last: 16'd9,      lat: 3,  cmode: 1'b1,
                    exp_regions: 1,  exp_total: 64'd34};
        rows[4] = '{first: 16'hFFFE,   last: 16'hFFFF,   lat: 5,  cmode: 1'b1,
                    exp_regions: 2,  exp_total: 64'd393221};

        repeat (3) tick();
        chk("rst_blk_start",    64'(blk_start),    64'd0);
        chk("rst_blk_restart",  64'(blk_restart),  64'd0);
        chk("rst_blk_region",   64'(blk_region),   64'd0);
        chk("rst_total",        total_count,       64'd0);
        chk("rst_regions_done", 64'(regions_done), 64'd0);
        chk("rst_busy_done",    64'({busy, done}), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 5; r++) begin
            bit ok;
            cur_lat   = rows[r].lat;
            cur_cmode = rows[r].cmode;
            nstarts   = 0;
            disp_cnt.delete();
            pulse_start(rows[r].first, rows[r].last);
            if (rows[r].exp_regions == 0) begin
                repeat (30) tick();
                chk($sformatf("row%0d_no_start", r), 64'(nstarts), 64'd0);
                chk($sformatf("row%0d_busy_done", r), 64'({busy, done}), 64'd0);
            end else begin
                wait_done(2000);
                chk($sformatf("row%0d_done", r), 64'(done), 64'd1);
                chk($sformatf("row%0d_busy", r), 64'(busy), 64'd0);
                chk($sformatf("row%0d_regions_done", r), 64'(regions_done),
                    64'(rows[r].exp_regions));
                chk($sformatf("row%0d_total", r), total_count, rows[r].exp_total);
                chk($sformatf("row%0d_nstarts", r), 64'(nstarts), 64'(rows[r].exp_regions));
                ok = 1'b1;
                for (int g = int'(rows[r].first); g <= int'(rows[r].last); g++) begin
                    if (!disp_cnt.exists(g) || disp_cnt[g] != 1) ok = 1'b0;
                end
                chk($sformatf("row%0d_each_once", r), 64'(ok), 64'd1);
                if (r == 1) begin
                    ok = (start_cyc[1] == start_cyc[0] + 1) &&
                         (start_cyc[2] == start_cyc[0] + 2) &&
                         (start_cyc[3] == start_cyc[0] + 3);
                    chk("row1_consecutive_starts", 64'(ok), 64'd1);
                end
            end
        end

        // simultaneous done on slots 1 and 2
        man       = 1'b1;
        man_done  = '0;
        cur_cmode = 1'b0;
        pulse_start(16'd0, 16'd3);
        repeat (6) tick();
        chk("sim_all_busy", 64'(busy), 64'd1);
        man_done = 4'b0110;
        tick();
        chk("sim_restart1", 64'(blk_restart), 64'b0010);
        chk("sim_total1",   total_count,      64'd2);
        tick();
        chk("sim_restart2", 64'(blk_restart), 64'b0100);
        chk("sim_total2",   total_count,      64'd5);
        tick();
        chk("sim_stale_done_ignored", 64'(blk_restart),  64'd0);
        chk("sim_regions_done",       64'(regions_done), 64'd2);
        man_done = '0;
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        chk("sim_abort_restart", 64'(blk_restart),      64'b1001);
        chk("sim_abort_state",   64'({busy, done}),     64'd0);
        chk("sim_total_kept",    total_count,           64'd5);

        // abort in RUN with three slots busy
        nstarts = 0;
        pulse_start(16'd0, 16'd9);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_restart", 64'(blk_restart),  64'b0111);
        chk("abort_nstarts", 64'(nstarts),      64'd3);
        chk("abort_idle",    64'({busy, done}), 64'd0);
        tick();
        chk("abort_no_more_start", 64'(blk_start), 64'd0);

        // abort and start together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        chk("abort_beats_start", 64'({busy, blk_start}), 64'd0);

        // reset mid-job issues no restart
        pulse_start(16'd0, 16'd3);
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        chk("rst_mid_restart", 64'(blk_restart), 64'd0);
        chk("rst_mid_busy",    64'(busy),        64'd0);
        rst_n = 1'b1;
        man   = 1'b0;
        tick();

        // N=4: range 14..15 must not wrap, counters all ones
        n4     = 0;
        first4 = 4'd14;
        last4  = 4'd15;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int k = 0; k < 20 && !done4; k++) tick();
        repeat (3) tick();
        chk("n4_done",         64'(done4),             64'd1);
        chk("n4_regions_done", 64'(regions_done4),     64'd2);
        chk("n4_total",        total4,                 64'h1FFF_FFFF_FFFF_FFFE);
        chk("n4_nstarts",      64'(n4),                64'd2);
        chk("n4_regions",      64'(blk_region4[7:0]),  64'hFE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
